// File: rtl/hc595_ctrl.sv
// hc595_ctrl: serialises a 16-bit {seg, sel} frame into two daisy-chained
// 74HC595s. Frames run back to back (16 x SHCP_DIV sys_clk cycles each); the
// inputs are snapshotted at the end of every frame so a frame never tears.
// All outputs are registered one cycle behind the counter state.
// Optional build macro: HC595_OE_BLANK_EN keeps oe high until the first
// valid latch; without it oe is high only while reset is asserted.
module hc595_ctrl #(
  parameter int SHCP_DIV = 4
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic [7:0] seg,
  input  logic [7:0] sel,
  output logic       ds,
  output logic       shcp,
  output logic       stcp,
  output logic       oe
);

  localparam int              FRAME_BITS = 16;
  localparam int              DIV_W      = $clog2(SHCP_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(SHCP_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_HALF  = DIV_W'(SHCP_DIV / 2);
  localparam logic [3:0]      BIT_LAST   = 4'(FRAME_BITS - 1);
  localparam logic [15:0]     SHADOW_RST = 16'hFF00;

  generate
    if (SHCP_DIV < 2 || (SHCP_DIV % 2) != 0) begin : g_bad_div
      $error("hc595_ctrl: SHCP_DIV must be even and >= 2");
    end
  endgenerate

  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic [3:0]       bit_cnt_q, bit_cnt_d;
  logic [15:0]      shadow_q, shadow_d;
  logic             first_done_q, first_done_d;
  logic             ds_q, ds_d;
  logic             shcp_q, shcp_d;
  logic             stcp_q, stcp_d;
  logic             oe_q, oe_d;

  logic             slot_end;
  logic             frame_end;

  // Frame boundary decode shared by the counters, shadow load and first_done.
  always_comb begin
    slot_end  = (div_cnt_q == DIV_LAST);
    frame_end = slot_end && (bit_cnt_q == BIT_LAST);
  end

  // Counters, snapshot register and first-frame flag.
  always_comb begin
    div_cnt_d    = div_cnt_q;
    bit_cnt_d    = bit_cnt_q;
    shadow_d     = shadow_q;
    first_done_d = first_done_q;

    if (slot_end) begin
      div_cnt_d = '0;
      bit_cnt_d = bit_cnt_q + 4'd1;
    end else begin
      div_cnt_d = div_cnt_q + DIV_W'(1);
    end

    if (frame_end) begin
      shadow_d     = {seg, sel};
      first_done_d = 1'b1;
    end
  end

  // Output pins, each derived from the current counter state so they lag it
  // by exactly one cycle. ds moves on div_cnt==0, i.e. as shcp falls.
  always_comb begin
    ds_d   = ds_q;
    shcp_d = (div_cnt_q >= DIV_HALF);
    stcp_d = first_done_q && (bit_cnt_q == '0) && (div_cnt_q < DIV_HALF);
`ifdef HC595_OE_BLANK_EN
    oe_d   = oe_q && !stcp_q;
`else
    oe_d   = 1'b0;
`endif

    if (div_cnt_q == '0) begin
      ds_d = shadow_q[BIT_LAST - bit_cnt_q];
    end
  end

  // State register with asynchronous active-low reset.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      div_cnt_q    <= '0;
      bit_cnt_q    <= '0;
      shadow_q     <= SHADOW_RST;
      first_done_q <= 1'b0;
      ds_q         <= 1'b0;
      shcp_q       <= 1'b0;
      stcp_q       <= 1'b0;
      oe_q         <= 1'b1;
    end else begin
      div_cnt_q    <= div_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      shadow_q     <= shadow_d;
      first_done_q <= first_done_d;
      ds_q         <= ds_d;
      shcp_q       <= shcp_d;
      stcp_q       <= stcp_d;
      oe_q         <= oe_d;
    end
  end

  assign ds   = ds_q;
  assign shcp = shcp_q;
  assign stcp = stcp_q;
  assign oe   = oe_q;

endmodule

// File: doc/hc595_ctrl.md
# hc595_ctrl

Serializer stage directly downstream of the static seven-segment driver. It takes the parallel segment pattern `seg[7:0]` and digit-select `sel[7:0]` and continuously shifts them into two daisy-chained 74HC595 shift registers on the display board. It drives the serial data line, the shift clock and the storage (latch) clock, plus an active-low output enable. Inputs are snapshotted once per frame, so display data never tears mid-frame.

## Interface
- `SHCP_DIV`, default 4: `sys_clk` cycles per `shcp` period; even, ≥2.
- `FRAME_BITS`, fixed 16: bits per frame (8 seg + 8 sel); not overridable.

- `sys_clk`  in  1  system clock.
- `sys_rst_n`  in  1  reset: asynchronous, active-low; clock `sys_clk`.
- `seg`  in  8  segment pattern, active-low segments.
- `sel`  in  8  digit select.
- `ds`  out  1  serial data to 595 DS.
- `shcp`  out  1  shift clock; 595 samples `ds` on rising edge.
- `stcp`  out  1  storage clock; 595 transfers shift register to outputs on rising edge.
- `oe`  out  1  595 output enable, active-low.

## Operation
- `div_cnt`: counts 0..SHCP_DIV-1 and wraps.
- `bit_cnt`: 0..15; increments when `div_cnt`==SHCP_DIV-1; wraps 15→0.
- Shadow register `shadow[15:0]`:
  - Loads `{seg, sel}` on the cycle where `bit_cnt`==15 and `div_cnt`==SHCP_DIV-1.
  - Reset value is 16'hFF00 (all segments blank, all digits selected).
  - Input changes at any other time do not affect the frame in progress.
- Bit order is MSB first. Bit slot k carries `shadow[15-k]`: `seg[7]` first, `sel[0]` last.
- Frame length: 16×SHCP_DIV cycles (64 at default), back to back, no idle gap.
- `stcp` pulses during bit slot 0 of each frame, latching the previously completed frame. The pulse is suppressed in the first frame after reset, because the chain then holds no complete data.
- `first_done` flag:
  - Cleared by reset.
  - Set at the end of the first frame.
  - Gates `stcp`.

## Timing
- All outputs are registered. Each output reflects the counter state of the previous cycle (1-cycle lag).
- `ds`: updates when the lagged `div_cnt`==0 (on the `shcp` falling edge). It is stable for the full `shcp` period, giving SHCP_DIV/2 cycles of setup before the rising edge.
- `shcp`: 0 while lagged `div_cnt` < SHCP_DIV/2, 1 otherwise. 50% duty.
- `stcp`: 1 while lagged `bit_cnt`==0, lagged `div_cnt` < SHCP_DIV/2 and `first_done`==1. Its rising edge comes exactly SHCP_DIV/2 cycles after the 16th `shcp` rise of the prior frame.
- Reset values: `ds`=0, `shcp`=0, `stcp`=0, `oe`=1; `div_cnt`=0, `bit_cnt`=0, `first_done`=0.
- Reset asserted mid-frame:
  - All outputs and counters return to their reset values immediately (asynchronous).
  - The partial frame is discarded; no `stcp` is generated for it.
  - After release, the first frame again suppresses `stcp`.
- Input change on the snapshot cycle itself: the value present at that clock edge is captured.
- SHCP_DIV=2: `shcp` toggles every cycle; `ds` still changes only while `shcp`=0.

## Configuration
- `HC595_OE_BLANK_EN`:
  - Defined: `oe` stays 1 from reset until the cycle after the first `stcp` rising edge, then stays 0. The display stays dark until valid data is latched.
  - Undefined: `oe` is 1 only while reset is asserted, and goes to 0 on the first clock after reset release.

## Test plan
- Reset check: hold reset 5 cycles → `ds`=0, `shcp`=0, `stcp`=0, `oe`=1. After release at SHCP_DIV=4, `shcp` period is 4 cycles and the frame period is 64 cycles.
- Single frame, `seg`=8'hC0, `sel`=8'hFE:
  - `ds` sampled on 16 `shcp` rises in the second frame reads 1,1,0,0,0,0,0,0,1,1,1,1,1,1,1,0.
  - `stcp` pulses once at the start of the third frame.
  - A behavioural two-595 model shows Q outputs equal to 16'hC0FE.
- Mid-frame change: set `seg`=8'hF9 at bit slot 5 of frame N → frame N keeps the old data; frame N+1 shifts F9.
- First-frame suppression: no `stcp` high in cycles 0..64 after reset; first `stcp` rise at cycle 66 (±1 lag).
- Reset mid-frame: assert reset at bit slot 9 → all outputs drop to reset values within the same cycle. After release, no `stcp` appears for 64 cycles.
- `HC595_OE_BLANK_EN`:
  - Defined: `oe` falls 1 cycle after the first `stcp` rise.
  - Undefined: `oe`=0 from the first post-reset cycle.
  - Repeat both with SHCP_DIV=2; the frame period is then 32 cycles.
